// File: rtl/frame_scaler_if.sv
// Scaler bus: raster coordinates/timing in, RAM read port, delayed pixel/timing out.
interface frame_scaler_if #(
  parameter int img_width_p   = 158,
  parameter int img_height_p  = 118,
  parameter int pixel_width_p = 4,
  parameter int max_scale_p   = 4
) ();
  localparam int addr_w_lp  = $clog2(img_width_p*img_height_p);
  localparam int scale_w_lp = $clog2(max_scale_p+1);

  logic signed [15:0]        sx_i, sy_i;
  logic                      de_i, hsync_i, vsync_i;
  logic                      frame_i, enable_i;
  logic [scale_w_lp-1:0]     scale_i;
  logic [addr_w_lp-1:0]      rd_addr_o;
  logic                      rd_en_o;
  logic [pixel_width_p-1:0]  rd_data_i;
  logic [pixel_width_p-1:0]  pixel_o;
  logic                      de_o, hsync_o, vsync_o, paint_o;

  // scaler side
  modport slave (
    input  sx_i, sy_i, de_i, hsync_i, vsync_i, frame_i, enable_i, scale_i, rd_data_i,
    output rd_addr_o, rd_en_o, pixel_o, de_o, hsync_o, vsync_o, paint_o
  );

  // timing generator / RAM / output register side
  modport master (
    output sx_i, sy_i, de_i, hsync_i, vsync_i, frame_i, enable_i, scale_i, rd_data_i,
    input  rd_addr_o, rd_en_o, pixel_o, de_o, hsync_o, vsync_o, paint_o
  );
endinterface

// File: rtl/frame_scaler.sv
// Framebuffer-to-display scaler: raster coords -> RAM address via counters,
// then RAM data or border colour, with sync/de delayed to line up with the pixel.
module frame_scaler #(
  parameter int img_width_p    = 158,
  parameter int img_height_p   = 118,
  parameter int pixel_width_p  = 4,
  parameter int max_scale_p    = 4,
  parameter int rd_latency_p   = 1,
  parameter int x0_p           = 0,
  parameter int y0_p           = 0,
  parameter int border_color_p = 5
) (
  input  logic           clk_i,
  input  logic           reset_i,
  frame_scaler_if.slave  bus
);
  localparam int AW = $clog2(img_width_p*img_height_p);
  localparam int SW = $clog2(max_scale_p+1);
  localparam int CW = $clog2(img_width_p);
  localparam int L  = rd_latency_p + 2;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic win;
  } tmg_t;

  logic [SW-1:0] s_q, s_d, x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] row_base_q, row_base_d, rd_addr_q, rd_addr_d;
  logic          frame_seen_q, frame_seen_d, rd_en_q;
  logic [pixel_width_p-1:0] pixel_q;
  tmg_t [L:1]    tpipe_q;
  logic [L:1]    vld_pipe_q;
  tmg_t          tmg_in;
  int            w_span, h_span, sx, sy;
  logic          x_in, y_in, win, last_x, scale_ok;

  // Window extent for the latched scale (constant mux, no multiplier) and window test
  always_comb begin
    w_span = img_width_p;
    h_span = img_height_p;
    for (int k = 1; k <= max_scale_p; k++) begin
      if (s_q == SW'(k)) begin
        w_span = img_width_p * k;
        h_span = img_height_p * k;
      end
    end
    sx     = int'(bus.sx_i);
    sy     = int'(bus.sy_i);
    x_in   = (sx >= x0_p) && (sx < x0_p + w_span);
    y_in   = (sy >= y0_p) && (sy < y0_p + h_span);
    last_x = (sx == x0_p + w_span - 1);
    win    = frame_seen_q & bus.enable_i & x_in & y_in;
    tmg_in = '{de: bus.de_i, hs: bus.hsync_i, vs: bus.vsync_i, win: win};
  end

  // Next state of scale latch and address counters; counters only move on window pixels
  always_comb begin
    s_d          = s_q;
    frame_seen_d = frame_seen_q;
    x_sub_d      = x_sub_q;
    col_d        = col_q;
    y_sub_d      = y_sub_q;
    row_base_d   = row_base_q;
    rd_addr_d    = rd_addr_q;
    scale_ok     = (bus.scale_i != '0) && (bus.scale_i <= SW'(max_scale_p));
    if (win) rd_addr_d = row_base_q + AW'(col_q);
    if (bus.frame_i) begin
      s_d          = scale_ok ? bus.scale_i : SW'(1);
      frame_seen_d = 1'b1;
      x_sub_d      = '0;
      col_d        = '0;
      y_sub_d      = '0;
      row_base_d   = '0;
    end else if (win) begin
      if (last_x) begin
        x_sub_d = '0;
        col_d   = '0;
        if (y_sub_q == s_q - SW'(1)) begin
          y_sub_d    = '0;
          row_base_d = row_base_q + AW'(img_width_p);
        end else begin
          y_sub_d = y_sub_q + SW'(1);
        end
      end else if (x_sub_q == s_q - SW'(1)) begin
        x_sub_d = '0;
        col_d   = col_q + CW'(1);
      end else begin
        x_sub_d = x_sub_q + SW'(1);
      end
    end
  end

  // Control registers: scale, counters, registered read address/strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_q          <= SW'(1);
      frame_seen_q <= 1'b0;
      x_sub_q      <= '0;
      col_q        <= '0;
      y_sub_q      <= '0;
      row_base_q   <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
    end else begin
      s_q          <= s_d;
      frame_seen_q <= frame_seen_d;
      x_sub_q      <= x_sub_d;
      col_q        <= col_d;
      y_sub_q      <= y_sub_d;
      row_base_q   <= row_base_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= win;
    end
  end

  // Delay lines for timing/window flags; pixel register samples RAM data when its slot was in-window
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tpipe_q    <= '0;
      vld_pipe_q <= '0;
      pixel_q    <= '0;
    end else begin
      tpipe_q    <= {tpipe_q[L-1:1], tmg_in};
      vld_pipe_q <= {vld_pipe_q[L-1:1], 1'b1};
      pixel_q    <= tpipe_q[L-1].win ? bus.rd_data_i : pixel_width_p'(border_color_p);
    end
  end

  // Pixel stays 0 until the delay line has refilled after reset
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_en_o   = rd_en_q;
  assign bus.pixel_o   = vld_pipe_q[L] ? pixel_q : '0;
  assign bus.de_o      = tpipe_q[L].de;
  assign bus.hsync_o   = tpipe_q[L].hs;
  assign bus.vsync_o   = tpipe_q[L].vs;
  assign bus.paint_o   = tpipe_q[L].win;
endmodule

// File: tb/tb_frame_scaler.sv
// Directed bench: two scalers (RAM latency 1 and 3) share one raster stimulus;
// each RAM model returns addr[3:0] after its latency.
module tb_frame_scaler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] sx, sy;
  logic               de, hs, vs, frame, enable;
  logic [2:0]         scale;
  int                 checks = 0, errors = 0;

  frame_scaler_if bus1 ();
  frame_scaler_if bus3 ();

  assign bus1.sx_i = sx;      assign bus3.sx_i = sx;
  assign bus1.sy_i = sy;      assign bus3.sy_i = sy;
  assign bus1.de_i = de;      assign bus3.de_i = de;
  assign bus1.hsync_i = hs;   assign bus3.hsync_i = hs;
  assign bus1.vsync_i = vs;   assign bus3.vsync_i = vs;
  assign bus1.frame_i = frame; assign bus3.frame_i = frame;
  assign bus1.enable_i = enable; assign bus3.enable_i = enable;
  assign bus1.scale_i = scale; assign bus3.scale_i = scale;

  frame_scaler #(.rd_latency_p(1)) dut1 (.clk_i(clk), .reset_i(rst), .bus(bus1));
  frame_scaler #(.rd_latency_p(3)) dut3 (.clk_i(clk), .reset_i(rst), .bus(bus3));

  // RAM models
  logic [3:0] m1;
  logic [3:0] m3 [3];
  always @(posedge clk) begin
    m1    <= bus1.rd_addr_o[3:0];
    m3[0] <= bus3.rd_addr_o[3:0];
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign bus1.rd_data_i = m1;
  assign bus3.rd_data_i = m3[2];

  typedef struct {
    string name;
    int    sc;
    bit    en;
    int    x, y;
    bit    exp_en;
    int    exp_addr;
  } tv_t;

  tv_t tv[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int x, input int y, input bit mark);
    sx = 16'(x);
    sy = 16'(y);
    de = (x >= 0 && x < 640 && y >= 0 && y < 480);
    hs = mark;
    vs = mark;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int sc);
    scale = 3'(sc);
    frame = 1'b1;
    step(-1, -1, 0);
    frame = 1'b0;
    scale = 3'd2;  // mid-frame change must be ignored
  endtask

  // Scan the raster from the frame start to (x,y), marking that pixel, then check
  // address one cycle later and pixel/timing 3 (lat 1) and 5 (lat 3) cycles later.
  task automatic run_vec(input tv_t v);
    int se, pix;
    bit tde;
    se  = (v.sc == 0 || v.sc > 4) ? 1 : v.sc;
    tde = (v.x >= 0 && v.x < 640 && v.y >= 0 && v.y < 480);
    pix = v.exp_en ? (v.exp_addr & 15) : 5;
    enable = v.en;
    start_frame(v.sc);
    for (int y = 0; y < v.y; y++)
      for (int x = -1; x <= 158*se; x++) step(x, y, 0);
    for (int x = -1; x < v.x; x++) step(x, v.y, 0);
    step(v.x, v.y, 1);
    check({v.name, " rd_en1"}, int'(bus1.rd_en_o), int'(v.exp_en));
    check({v.name, " rd_en3"}, int'(bus3.rd_en_o), int'(v.exp_en));
    if (v.exp_en) begin
      check({v.name, " addr1"}, int'(bus1.rd_addr_o), v.exp_addr);
      check({v.name, " addr3"}, int'(bus3.rd_addr_o), v.exp_addr);
    end
    step(-1, v.y, 0);
    check({v.name, " hsync1 early"}, int'(bus1.hsync_o), 0);
    step(-1, v.y, 0);
    check({v.name, " pixel1"}, int'(bus1.pixel_o), pix);
    check({v.name, " paint1"}, int'(bus1.paint_o), int'(v.exp_en));
    check({v.name, " de1"}, int'(bus1.de_o), int'(tde));
    check({v.name, " hsync1"}, int'(bus1.hsync_o), 1);
    check({v.name, " vsync1"}, int'(bus1.vsync_o), 1);
    step(-1, v.y, 0);
    check({v.name, " hsync3 early"}, int'(bus3.hsync_o), 0);
    step(-1, v.y, 0);
    check({v.name, " pixel3"}, int'(bus3.pixel_o), pix);
    check({v.name, " paint3"}, int'(bus3.paint_o), int'(v.exp_en));
    check({v.name, " hsync3"}, int'(bus3.hsync_o), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_en1"}, int'(bus1.rd_en_o), 0);
    check({tag, " addr1"},  int'(bus1.rd_addr_o), 0);
    check({tag, " pixel1"}, int'(bus1.pixel_o), 0);
    check({tag, " de1"},    int'(bus1.de_o), 0);
    check({tag, " paint1"}, int'(bus1.paint_o), 0);
    check({tag, " rd_en3"}, int'(bus3.rd_en_o), 0);
    check({tag, " pixel3"}, int'(bus3.pixel_o), 0);
    check({tag, " de3"},    int'(bus3.de_o), 0);
  endtask

  initial begin
    // name, scale_i, enable_i, x, y, expected rd_en, expected addr
    tv[0]  = '{"s1_origin",   1, 1'b1,   0,   0, 1'b1,     0};
    tv[1]  = '{"s1_line_end", 1, 1'b1, 157,   0, 1'b1,   157};
    tv[2]  = '{"s1_line1",    1, 1'b1,   0,   1, 1'b1,   158};
    tv[3]  = '{"s1_last",     1, 1'b1, 157, 117, 1'b1, 18643};
    tv[4]  = '{"s1_past_x",   1, 1'b1, 158,   0, 1'b0,     0};
    tv[5]  = '{"s1_past_y",   1, 1'b1,   0, 118, 1'b0,     0};
    tv[6]  = '{"s4_5_3",      4, 1'b1,   5,   3, 1'b1,     1};
    tv[7]  = '{"s4_past_x",   4, 1'b1, 632,   0, 1'b0,     0};
    tv[8]  = '{"s2_next",     2, 1'b1,   2,   2, 1'b1,   159};
    tv[9]  = '{"s3_edge",     3, 1'b1, 473,   4, 1'b1,   315};
    tv[10] = '{"s0_as_1",     0, 1'b1,   3,   2, 1'b1,   319};
    tv[11] = '{"s7_as_1",     7, 1'b1,  10,   1, 1'b1,   168};
    tv[12] = '{"en0",         1, 1'b0,   5,   0, 1'b0,     0};

    rst = 1'b1; frame = 1'b0; enable = 1'b1; scale = 3'd1;
    sx = 0; sy = 0; de = 0; hs = 0; vs = 0;

    // Reset state with active-looking inputs
    step(0, 0, 0);
    step(1, 0, 0);
    check_zero("reset");
    check("reset hsync1", int'(bus1.hsync_o), 0);

    // No frame_i yet: window inactive, border once pipeline fills
    rst = 1'b0;
    step(0, 0, 0);
    check("preframe rd_en1", int'(bus1.rd_en_o), 0);
    step(1, 0, 0);
    step(2, 0, 0);
    check("preframe rd_en1b", int'(bus1.rd_en_o), 0);
    check("preframe pixel1", int'(bus1.pixel_o), 5);
    check("preframe paint1", int'(bus1.paint_o), 0);

    for (int i = 0; i < 13; i++) run_vec(tv[i]);

    // enable_i low mid-line freezes counters
    enable = 1'b1;
    start_frame(1);
    for (int x = -1; x <= 4; x++) step(x, 0, 0);
    enable = 1'b0;
    step(5, 0, 0);
    check("freeze rd_en1", int'(bus1.rd_en_o), 0);
    for (int x = 6; x <= 9; x++) step(x, 0, 0);
    enable = 1'b1;
    step(10, 0, 0);
    check("freeze rd_en1 resume", int'(bus1.rd_en_o), 1);
    check("freeze addr1", int'(bus1.rd_addr_o), 5);

    // Reset mid-line
    start_frame(1);
    for (int x = -1; x <= 9; x++) step(x, 0, 0);
    check("midline addr1", int'(bus1.rd_addr_o), 9);
    rst = 1'b1;
    step(10, 0, 0);
    check_zero("midreset");
    rst = 1'b0;
    step(11, 0, 0);
    check("postreset rd_en1", int'(bus1.rd_en_o), 0);
    step(12, 0, 0);
    check("postreset rd_en3", int'(bus3.rd_en_o), 0);
    run_vec('{"resume", 1, 1'b1, 4, 0, 1'b1, 4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
